// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Control FSM for the PC / instruction-register / memory register block.
// It walks each instruction through FETCH, DECODE, EXEC or MEM, and WB.
// Along the way it drives the write enables, memory strobes and address
// select, and it waits on a memory-ready handshake. It also counts retired
// instructions and raises a sticky error when a memory access times out.
//
// Ports
//   clk        in   1     system clock, rising edge
//   rst        in   1     asynchronous active-high reset
//   start      in   1     level; leaves IDLE and begins fetching at current PC
//   opcode     in   OPW   opcode field from IR, valid from DECODE onward
//   mem_ready  in   1     memory completes the current access this cycle
//   mem_re     out  1     memory read strobe
//   mem_we     out  1     memory write strobe
//   addr_sel   out  1     0 = address from PC, 1 = data address register
//   ir_we      out  1     instruction register load
//   pc_we      out  1     PC register load
//   pc_sel     out  1     0 = PC+4, 1 = jump target
//   reg_we     out  1     register-file write-back
//   state      out  3     current state encoding (debug)
//   retire     out  1     one-cycle pulse per completed instruction
//   icount     out  CNTW  retired-instruction count (wraps)
//   err        out  1     sticky memory-timeout flag
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int                 OPW      = 6,
    parameter logic [OPW-1:0]     OP_LOAD  = 6'h23,
    parameter logic [OPW-1:0]     OP_STORE = 6'h2B,
    parameter logic [OPW-1:0]     OP_JUMP  = 6'h02,
    parameter logic [OPW-1:0]     OP_HALT  = 6'h3F,
    parameter int                 TIMEOUT  = 15,
    parameter int                 CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_ready,
    output logic            mem_re,
    output logic            mem_we,
    output logic            addr_sel,
    output logic            ir_we,
    output logic            pc_we,
    output logic            pc_sel,
    output logic            reg_we,
    output logic [2:0]      state,
    output logic            retire,
    output logic [CNTW-1:0] icount,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [7:0]      TIMEOUT_W = 8'(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_nxt_s;
    logic [7:0]      wait_r;
    logic [7:0]      wait_nxt_s;
    logic            wait_inc_s;
    logic [CNTW-1:0] icount_r;
    logic            err_r;

    logic            is_load_s;
    logic            is_store_s;
    logic            is_jump_s;
    logic            is_halt_s;
    logic            timed_out_s;

    assign is_load_s  = (opcode == OP_LOAD);
    assign is_store_s = (opcode == OP_STORE);
    assign is_jump_s  = (opcode == OP_JUMP);
    assign is_halt_s  = (opcode == OP_HALT);

    // The wait counter has reached its limit; a further not-ready cycle is fatal.
    assign timed_out_s = (wait_r == TIMEOUT_W);

    // Next-state and strobe decode from state, opcode and mem_ready.
    always_comb begin
        state_nxt_s = state_r;
        wait_inc_s  = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        reg_we      = 1'b0;
        retire      = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end

            S_FETCH: begin
                addr_sel = 1'b0;
                if (mem_ready) begin
                    // A ready on the limit cycle still completes the fetch.
                    mem_re      = 1'b1;
                    ir_we       = 1'b1;
                    pc_we       = 1'b1;
                    pc_sel      = 1'b0;
                    state_nxt_s = S_DECODE;
                end else if (timed_out_s) begin
                    // Give up: strobe is withheld on the abandoning cycle.
                    state_nxt_s = S_ERROR;
                end else begin
                    mem_re     = 1'b1;
                    wait_inc_s = 1'b1;
                end
            end

            S_DECODE: begin
                if (is_halt_s) begin
                    retire      = 1'b1;
                    state_nxt_s = S_HALTED;
                end else if (is_jump_s) begin
                    pc_we       = 1'b1;
                    pc_sel      = 1'b1;
                    retire      = 1'b1;
                    state_nxt_s = S_FETCH;
                end else if (is_load_s || is_store_s) begin
                    state_nxt_s = S_MEM;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end

            S_EXEC: begin
                state_nxt_s = S_WB;
            end

            S_MEM: begin
                addr_sel = 1'b1;
                if (mem_ready) begin
                    if (is_load_s) begin
                        mem_re      = 1'b1;
                        state_nxt_s = S_WB;
                    end else begin
                        // Store completes here; nothing to write back.
                        mem_we      = 1'b1;
                        retire      = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                end else if (timed_out_s) begin
                    state_nxt_s = S_ERROR;
                end else begin
                    if (is_load_s) begin
                        mem_re = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                    wait_inc_s = 1'b1;
                end
            end

            S_WB: begin
                reg_we      = 1'b1;
                retire      = 1'b1;
                state_nxt_s = S_FETCH;
            end

            S_HALTED: begin
                state_nxt_s = S_HALTED;
            end

            S_ERROR: begin
                state_nxt_s = S_ERROR;
            end

            default: begin
                state_nxt_s = S_ERROR;
            end
        endcase
    end

    // Wait counter next value: cleared on any state change.
    always_comb begin
        wait_nxt_s = wait_r;
        if (state_nxt_s != state_r) begin
            wait_nxt_s = 8'd0;
        end else if (wait_inc_s) begin
            wait_nxt_s = wait_r + 8'd1;
        end else begin
            wait_nxt_s = wait_r;
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            wait_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icount_r <= {CNTW{1'b0}};
        end else if (retire) begin
            icount_r <= icount_r + CNT_ONE;
        end else begin
            icount_r <= icount_r;
        end
    end

    // Sticky timeout flag, set on entry to ERROR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (state_nxt_s == S_ERROR) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign state  = state_r;
    assign icount = icount_r;
    assign err    = err_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Self-checking bench for multicycle_sequencer. Inputs change on the falling
// edge and outputs are sampled 1-2 time units later. Each instruction pushes
// its expected retire record (icount before retire, reg_we on retire) to a
// scoreboard queue. A monitor pops that record whenever retire pulses. A
// second instance with a 4-bit counter exercises the wrap of icount.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam int         TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [5:0]  opcode = 6'h00;

    logic        mem_re, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, retire, err;
    logic [2:0]  state;
    logic [15:0] icount;

    logic        n_mem_re, n_mem_we, n_addr_sel, n_ir_we, n_pc_we, n_pc_sel;
    logic        n_reg_we, n_retire, n_err;
    logic [2:0]  n_state;
    logic [3:0]  n_icount;

    typedef struct {
        logic [15:0] icnt;
        logic        reg_we;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] exp_icount = 16'd0;
    int          n_checks = 0;
    int          n_errors = 0;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .mem_re(mem_re), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .state(state),
        .retire(retire), .icount(icount), .err(err)
    );

    multicycle_sequencer #(.CNTW(4)) dut_narrow (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .mem_re(n_mem_re), .mem_we(n_mem_we), .addr_sel(n_addr_sel), .ir_we(n_ir_we),
        .pc_we(n_pc_we), .pc_sel(n_pc_sel), .reg_we(n_reg_we), .state(n_state),
        .retire(n_retire), .icount(n_icount), .err(n_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic st, input logic rdy, input logic [5:0] op);
        @(negedge clk);
        start     = st;
        mem_ready = rdy;
        opcode    = op;
        #1;
    endtask

    // Scoreboard monitor: every retire pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (retire === 1'b1) begin
                check_eq("retire_pending", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("sb_icount", {16'd0, icount}, {16'd0, e.icnt});
                    check_eq("sb_icount_narrow", {28'd0, n_icount}, {28'd0, e.icnt[3:0]});
                    check_eq("sb_reg_we", {31'd0, reg_we}, {31'd0, e.reg_we});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
        #1;
        check_eq("rst_state", {29'd0, state}, 32'd0);
        check_eq("rst_icount", {16'd0, icount}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_outs", {26'd0, mem_re, mem_we, ir_we, pc_we, reg_we, retire}, 32'd0);
        check_eq("rst_sb_drained", sb_q.size(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_icount = 16'd0;
        sb_q.delete();
    endtask

    // Leave IDLE; the state seen in the start cycle is still IDLE.
    task automatic kick();
        tick(1'b1, 1'b0, 6'h00);
        check_eq("idle_state", {29'd0, state}, 32'd0);
    endtask

    // One instruction from FETCH with fw fetch waits and mw memory waits.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        exp_t e;
        logic is_ld, is_st;
        is_ld = (op == OP_LOAD);
        is_st = (op == OP_STORE);
        e.icnt   = exp_icount;
        e.reg_we = !(is_st || op == OP_JUMP || op == OP_HALT);
        sb_q.push_back(e);
        exp_icount++;
        for (int i = 0; i < fw; i++) begin
            tick(1'b0, 1'b0, op);
            check_eq("fetch_wait", {29'd0, state, mem_re, ir_we}, {29'd0, 3'd1, 1'b1, 1'b0});
        end
        tick(1'b0, 1'b1, op);
        check_eq("fetch_state", {29'd0, state}, 32'd1);
        check_eq("fetch_ctl", {27'd0, mem_re, addr_sel, ir_we, pc_we, pc_sel}, {27'd0, 5'b10110});
        tick(1'b0, 1'($urandom_range(0, 1)), op);
        check_eq("decode_state", {29'd0, state}, 32'd2);
        if (op == OP_HALT) begin
            check_eq("halt_retire", {31'd0, retire}, 32'd1);
            return;
        end
        if (op == OP_JUMP) begin
            check_eq("jump_ctl", {29'd0, pc_we, pc_sel, retire}, {29'd0, 3'b111});
            return;
        end
        check_eq("decode_pc_we", {31'd0, pc_we}, 32'd0);
        if (is_ld || is_st) begin
            for (int i = 0; i <= mw; i++) begin
                tick(1'b0, 1'(i == mw), op);
                check_eq("mem_state", {29'd0, state}, 32'd4);
                check_eq("mem_ctl", {29'd0, addr_sel, mem_re, mem_we}, {29'd0, 1'b1, is_ld, is_st});
                check_eq("mem_retire", {31'd0, retire}, {31'd0, 1'(is_st && i == mw)});
            end
            if (is_st) return;
        end else begin
            tick(1'b0, 1'($urandom_range(0, 1)), op);
            check_eq("exec_state", {29'd0, state}, 32'd3);
            check_eq("exec_ctl", {26'd0, mem_re, mem_we, reg_we, pc_we, ir_we, retire}, 32'd0);
        end
        tick(1'b0, 1'($urandom_range(0, 1)), op);
        check_eq("wb_state", {29'd0, state}, 32'd5);
        check_eq("wb_ctl", {30'd0, reg_we, retire}, {30'd0, 2'b11});
    endtask

    // Starved access: limit cycle withholds the strobe, then ERROR sticks.
    task automatic expect_timeout(input logic [2:0] st_exp);
        for (int i = 0; i < TIMEOUT; i++) begin
            tick(1'b0, 1'b0, opcode);
            check_eq("to_wait_state", {29'd0, state}, {29'd0, st_exp});
        end
        tick(1'b0, 1'b0, opcode);
        check_eq("to_last_state", {29'd0, state}, {29'd0, st_exp});
        check_eq("to_no_strobe", {28'd0, mem_re, mem_we, ir_we, pc_we}, 32'd0);
        check_eq("to_err_pre", {31'd0, err}, 32'd0);
        tick(1'b1, 1'b1, opcode);
        check_eq("to_state", {29'd0, state}, 32'd7);
        check_eq("to_err", {31'd0, err}, 32'd1);
        tick(1'b1, 1'b1, opcode);
        check_eq("to_sticky", {28'd0, state, err}, {28'd0, 4'b1111});
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        int         k;
        k = $urandom_range(0, 3);
        case (k)
            0:       op = OP_LOAD;
            1:       op = OP_STORE;
            2:       op = OP_JUMP;
            default: begin
                op = 6'($urandom_range(0, 63));
                if (op == OP_LOAD || op == OP_STORE || op == OP_JUMP || op == OP_HALT) op = 6'h00;
            end
        endcase
        return op;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        kick();
        run_instr(6'h00, 0, 0);
        run_instr(6'h11, 0, 0);
        run_instr(6'h3E, 0, 0);
        run_instr(OP_LOAD, 0, 0);
        run_instr(OP_LOAD, 3, 2);
        run_instr(OP_STORE, 0, 3);
        run_instr(OP_JUMP, 0, 0);
        run_instr(6'h00, 1, 0);
        for (int n = 0; n < 14; n++) begin
            run_instr(rand_op(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        // Ready on the limit cycle wins, in both FETCH and MEM.
        run_instr(OP_LOAD, TIMEOUT, TIMEOUT);
        run_instr(OP_STORE, TIMEOUT, TIMEOUT);
        run_instr(OP_HALT, 0, 0);
        tick(1'b1, 1'b1, 6'h00);
        check_eq("halted_state", {29'd0, state}, 32'd6);
        check_eq("halted_count", {16'd0, icount}, {16'd0, exp_icount});
        check_eq("halted_count_narrow", {28'd0, n_icount}, {28'd0, exp_icount[3:0]});
        tick(1'b1, 1'b0, 6'h00);
        check_eq("halted_absorb", {29'd0, state}, 32'd6);

        // FETCH timeout.
        do_reset();
        kick();
        expect_timeout(3'd1);

        // MEM timeout on a load.
        do_reset();
        kick();
        tick(1'b0, 1'b1, OP_LOAD);
        tick(1'b0, 1'b0, OP_LOAD);
        check_eq("mto_decode", {29'd0, state}, 32'd2);
        expect_timeout(3'd4);

        // Reset during a pending store aborts it at once.
        do_reset();
        kick();
        run_instr(6'h05, 0, 0);
        tick(1'b0, 1'b1, OP_STORE);
        tick(1'b0, 1'b0, OP_STORE);
        tick(1'b0, 1'b0, OP_STORE);
        check_eq("abort_pre", {28'd0, state, mem_we}, {28'd0, 3'd4, 1'b1});
        check_eq("abort_pre_icount", {16'd0, icount}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_state", {29'd0, state}, 32'd0);
        check_eq("abort_outs", {25'd0, mem_re, mem_we, addr_sel, ir_we, pc_we, reg_we, retire}, 32'd0);
        check_eq("abort_icount", {16'd0, icount}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_icount = 16'd0;
        check_eq("final_sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
